bin2bcd_seq: RTL and testbench

Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It is the sequential counterpart of the combinational BCD-to-binary converter and shares its DECLEN/BINLEN sizing from bcd_size.vh. Operands are accepted on a valid/ready input handshake, and results are delivered on a valid/ready output handshake, so the block can sit between pipelined display and arithmetic stages.

---
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 tb/tb_bin2bcd_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction; adds 3 to a BCD digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative shift-and-add-3 binary-to-BCD converter, one bit
//               per clock, with valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int DECLEN = 9,
    parameter int BINLEN = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BINLEN-1:0]     BIN,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DECLEN*4-1:0]   BCD,
    output logic                  ovf
);

    localparam int C_BW = DECLEN * 4;
    localparam int C_CW = $clog2(BINLEN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [BINLEN-1:0]  r_bin;
    logic [C_BW-1:0]    r_bcd;
    logic               r_ovf;
    logic [C_CW-1:0]    r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [C_BW-1:0]        w_adj;
    logic [C_BW+BINLEN:0]   w_shift;
    logic [C_BW-1:0]        w_bcd_nxt;
    logic [BINLEN-1:0]      w_bin_nxt;
    logic                   w_carry;

    generate
        for (genvar gi = 0; gi < DECLEN; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_bcd[gi*4 +: 4]),
                .o_digit (w_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Built as one wide word so BINLEN=1 needs no zero-width slices; the
    // top bit is the carry out of the most significant digit.
    assign w_shift   = {w_adj, r_bin, 1'b0};
    assign w_bin_nxt = w_shift[BINLEN-1:0];
    assign w_bcd_nxt = w_shift[BINLEN +: C_BW];
    assign w_carry   = w_shift[C_BW+BINLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bin      <= BIN;
                        r_bcd      <= '0;
                        r_ovf      <= 1'b0;
                        r_cnt      <= C_CW'(BINLEN);
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bin <= w_bin_nxt;
                    r_bcd <= w_bcd_nxt;
                    r_ovf <= r_ovf | w_carry;
                    r_cnt <= r_cnt - C_CW'(1);
                    if (r_cnt == C_CW'(1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No bypass: in_ready only returns once the result has left.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign BCD       = r_bcd;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int DECLEN = 9;
    localparam int BINLEN = 30;
    localparam int TMO    = 200;
    localparam int NRAND  = 1000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] BIN       = '0;
    logic        in_ready;
    logic        out_valid;
    logic        ovf;
    logic [35:0] BCD;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] q_exp [$];

    bin2bcd_seq #(.DECLEN(DECLEN), .BINLEN(BINLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .BIN       (BIN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .BCD       (BCD),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Decimal reference: {ovf, BCD} computed with integer arithmetic.
    function automatic logic [36:0] ref_model(input logic [29:0] b);
        longint v;
        logic [35:0] d;
        logic o;
        v = longint'(b);
        o = (v >= 64'd1000000000);
        v = v % 1000000000;
        for (int i = 0; i < 9; i++) begin
            d[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {o, d};
    endfunction

    task automatic start(input logic [29:0] b);
        int w = 0;
        while (!in_ready && w < TMO) begin
            @(negedge clk);
            w++;
        end
        BIN      = b;
        in_valid = 1'b1;
        q_exp.push_back(ref_model(b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, ovf, BCD} !== {1'b1, 1'b0, 1'b0, 36'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b bcd=%h, want rdy=1 vld=0 ovf=0 bcd=0",
                     in_ready, out_valid, ovf, BCD);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [29:0] tbl   [5] = '{30'd0, 30'd255, 30'd999999999, 30'd1000000000, 30'h3FFFFFFF};
        logic [35:0] e_bcd [5] = '{36'h0, 36'h255, 36'h999999999, 36'h0, 36'h073741823};
        logic        e_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [36:0] exp;
        int lat;
        for (int i = 0; i < 5; i++) begin
            start(tbl[i]);
            wait_out(lat);
            n_tests++;
            if (lat !== BINLEN + 1) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d cycles, want %0d", tbl[i], lat, BINLEN + 1);
            end
            exp = q_exp.pop_front();
            n_tests++;
            if ({ovf, BCD} !== exp) begin
                n_fail++;
                $display("FAIL scoreboard[%0d]: got ovf=%b bcd=%h, want ovf=%b bcd=%h",
                         tbl[i], ovf, BCD, exp[36], exp[35:0]);
            end
            n_tests++;
            if ({ovf, BCD} !== {e_ovf[i], e_bcd[i]}) begin
                n_fail++;
                $display("FAIL directed[%0d]: got ovf=%b bcd=%h, want ovf=%b bcd=%h",
                         tbl[i], ovf, BCD, e_ovf[i], e_bcd[i]);
            end
            take();
            n_tests++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL release[%0d]: got vld=%b rdy=%b, want vld=0 rdy=1",
                         tbl[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] exp;
        int lat;
        int bad = 0;
        start(30'd12345);
        wait_out(lat);
        exp = q_exp.pop_front();
        n_tests++;
        if ({ovf, BCD} !== exp || BCD !== 36'h000012345) begin
            n_fail++;
            $display("FAIL bp_result: got ovf=%b bcd=%h, want ovf=%b bcd=%h", ovf, BCD, exp[36], exp[35:0]);
        end
        // A stray operand offered while stalled must be ignored.
        BIN      = 30'd5;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || BCD !== 36'h000012345 || ovf !== 1'b0)
                bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d of 50 stall cycles changed, want 0 (last bcd=%h vld=%b rdy=%b)",
                     bad, BCD, out_valid, in_ready);
        end
        take();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midop();
        logic [36:0] exp;
        int lat;
        int pulses = 0;
        start(30'd777);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, ovf, BCD} !== {1'b1, 1'b0, 1'b0, 36'h0}) begin
            n_fail++;
            $display("FAIL midop_reset: got rdy=%b vld=%b ovf=%b bcd=%h, want rdy=1 vld=0 ovf=0 bcd=0",
                     in_ready, out_valid, ovf, BCD);
        end
        q_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midop_no_pulse: out_valid high %0d cycles after reset, want 0", pulses);
        end
        start(30'd42);
        wait_out(lat);
        exp = q_exp.pop_front();
        n_tests++;
        if (lat !== BINLEN + 1 || {ovf, BCD} !== exp || BCD !== 36'h000000042) begin
            n_fail++;
            $display("FAIL midop_next: got lat=%0d ovf=%b bcd=%h, want lat=%0d ovf=0 bcd=000000042",
                     lat, ovf, BCD, BINLEN + 1);
        end
        take();
    endtask

    task automatic test_random_sweep();
        logic [36:0] exp;
        logic [29:0] b;
        int lat;
        int stall;
        for (int n = 0; n < NRAND; n++) begin
            b = 30'($urandom());
            if (n % 10 == 0) b = 30'd999999998 + 30'($urandom_range(0, 3));
            start(b);
            wait_out(lat);
            if (lat >= TMO) begin
                n_tests++;
                n_fail++;
                $display("FAIL sweep_timeout: bin=%0d no out_valid within %0d cycles", b, TMO);
                break;
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            exp = q_exp.pop_front();
            n_tests++;
            if ({ovf, BCD} !== exp) begin
                n_fail++;
                $display("FAIL sweep[%0d]: bin=%0d got ovf=%b bcd=%h, want ovf=%b bcd=%h",
                         n, b, ovf, BCD, exp[36], exp[35:0]);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
